// File: rtl/minibyte_bus_arbiter.sv
// Two-requester arbiter for the Minibyte external address/data/WE bus.
// Optional owner bus-lock is enabled by defining MINIBYTE_ARB_LOCK_EN.
module minibyte_bus_arbiter #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       halt_in,
`ifdef MINIBYTE_ARB_LOCK_EN
    input  logic       r0_lock_in,
    input  logic       r1_lock_in,
`endif
    input  logic       r0_req_in,
    input  logic [6:0] r0_addr_in,
    input  logic       r0_we_in,
    input  logic [7:0] r0_data_in,
    output logic       r0_ack_out,
    output logic [7:0] r0_data_out,
    input  logic       r1_req_in,
    input  logic [6:0] r1_addr_in,
    input  logic       r1_we_in,
    input  logic [7:0] r1_data_in,
    output logic       r1_ack_out,
    output logic [7:0] r1_data_out,
    input  logic [7:0] bus_data_in,
    output logic [6:0] bus_addr_out,
    output logic [7:0] bus_data_out,
    output logic       bus_we_out,
    output logic       bus_drive_out,
    output logic       busy_out,
    output logic       owner_out
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t     state_q, state_d;
    logic       owner_q;
    logic [6:0] addr_q;
    logic       we_q;
    logic [7:0] data_q;
    logic [3:0] cnt_q;
    logic [7:0] rd0_q, rd1_q;
    logic       grant;
    logic       grant_who;

`ifdef MINIBYTE_ARB_LOCK_EN
    logic       lock_hold_q;
`endif

    // Round-robin: on a tie the requester that did not own the last access wins.
    always_comb begin
        grant_who = r1_req_in;
        if (r0_req_in && r1_req_in)
            grant_who = ~owner_q;
`ifdef MINIBYTE_ARB_LOCK_EN
        if (lock_hold_q && (owner_q ? r1_req_in : r0_req_in))
            grant_who = owner_q;
`endif
        grant = (state_q == IDLE) && !halt_in && (r0_req_in || r1_req_in);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (cnt_q == 4'd0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q <= IDLE;
            owner_q <= 1'b1;
            addr_q  <= '0;
            we_q    <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
            rd0_q   <= '0;
            rd1_q   <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (grant) begin
                        owner_q <= grant_who;
                        addr_q  <= grant_who ? r1_addr_in : r0_addr_in;
                        we_q    <= grant_who ? r1_we_in   : r0_we_in;
                        data_q  <= grant_who ? r1_data_in : r0_data_in;
                    end
                end
                SETUP: cnt_q <= CNT_LOAD;
                ACCESS: begin
                    cnt_q <= cnt_q - 4'd1;
                    if (cnt_q == 4'd0 && !we_q) begin
                        if (owner_q) rd1_q <= bus_data_in;
                        else         rd0_q <= bus_data_in;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MINIBYTE_ARB_LOCK_EN
    // Lock is sampled on the DONE edge and consumed by the next grant.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)
            lock_hold_q <= 1'b0;
        else if (state_q == DONE)
            lock_hold_q <= owner_q ? r1_lock_in : r0_lock_in;
        else if (grant)
            lock_hold_q <= 1'b0;
    end
`endif

    always_comb begin
        busy_out      = (state_q != IDLE);
        bus_addr_out  = busy_out ? addr_q : '0;
        bus_drive_out = busy_out && we_q;
        bus_data_out  = bus_drive_out ? data_q : '0;
        bus_we_out    = (state_q == ACCESS) && we_q;
        r0_ack_out    = (state_q == DONE) && !owner_q;
        r1_ack_out    = (state_q == DONE) && owner_q;
        owner_out     = owner_q;
        r0_data_out   = rd0_q;
        r1_data_out   = rd1_q;
    end

endmodule

// File: tb/tb_minibyte_bus_arbiter.sv
// Randomized scoreboard bench for minibyte_bus_arbiter against a transaction-level model.
module tb_minibyte_bus_arbiter;

    localparam int W = 3;

    logic       clk_in = 1'b0;
    logic       rst_in = 1'b1;
    logic       halt_in = 1'b0;
`ifdef MINIBYTE_ARB_LOCK_EN
    logic       r0_lock_in = 1'b0;
    logic       r1_lock_in = 1'b0;
`endif
    logic       r0_req_in = 1'b0, r1_req_in = 1'b0;
    logic [6:0] r0_addr_in = '0, r1_addr_in = '0;
    logic       r0_we_in = 1'b0, r1_we_in = 1'b0;
    logic [7:0] r0_data_in = '0, r1_data_in = '0;
    logic       r0_ack_out, r1_ack_out;
    logic [7:0] r0_data_out, r1_data_out;
    logic [7:0] bus_data_in;
    logic [6:0] bus_addr_out;
    logic [7:0] bus_data_out;
    logic       bus_we_out, bus_drive_out, busy_out, owner_out;

    minibyte_bus_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .halt_in(halt_in),
`ifdef MINIBYTE_ARB_LOCK_EN
        .r0_lock_in(r0_lock_in), .r1_lock_in(r1_lock_in),
`endif
        .r0_req_in(r0_req_in), .r0_addr_in(r0_addr_in), .r0_we_in(r0_we_in),
        .r0_data_in(r0_data_in), .r0_ack_out(r0_ack_out), .r0_data_out(r0_data_out),
        .r1_req_in(r1_req_in), .r1_addr_in(r1_addr_in), .r1_we_in(r1_we_in),
        .r1_data_in(r1_data_in), .r1_ack_out(r1_ack_out), .r1_data_out(r1_data_out),
        .bus_data_in(bus_data_in), .bus_addr_out(bus_addr_out), .bus_data_out(bus_data_out),
        .bus_we_out(bus_we_out), .bus_drive_out(bus_drive_out),
        .busy_out(busy_out), .owner_out(owner_out)
    );

    always #5 clk_in = ~clk_in;

    // External memory seen on the bus: fixed contents, read at the presented address.
    logic [7:0] mem [128];
    assign bus_data_in = mem[bus_addr_out];

    typedef struct {
        int         who;
        logic [6:0] addr;
        logic       we;
        logic [7:0] data;
        int         g;
    } txn_t;

    txn_t       sb[$];
    int         n_tests = 0, n_fail = 0;
    int         edge_n = 0;
    int         next_free = 0;
    int         last_owner = 1;
    int         cur_g = -100, cur_who = 0;
    bit         hold = 1'b0;
    logic [7:0] exp_rd [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", nm, edge_n, act, exp);
        end
    endtask

    function automatic logic [31:0] pack_outs();
        return {11'b0, busy_out, owner_out, bus_addr_out, bus_we_out, bus_drive_out,
                bus_data_out, r0_ack_out, r1_ack_out};
    endfunction

    task automatic model_reset();
        sb.delete();
        next_free = 0;
        last_owner = 1;
        hold = 1'b0;
        cur_g = -100;
        exp_rd[0] = '0;
        exp_rd[1] = '0;
    endtask

    // Reference model: one access occupies W+3 grant opportunities; arbitration by rule.
    always @(posedge clk_in) begin
        bit [1:0] r;
        int       who;
        txn_t     t;
        edge_n++;
        if (rst_in) begin
            r = {r1_req_in, r0_req_in};
`ifdef MINIBYTE_ARB_LOCK_EN
            if (edge_n == cur_g + W + 2) hold = (cur_who == 1) ? r1_lock_in : r0_lock_in;
`endif
            if (edge_n >= next_free && !halt_in && r != 2'b00) begin
                if (r == 2'b11) who = 1 - last_owner;
                else            who = r[1] ? 1 : 0;
                if (hold && r[last_owner]) who = last_owner;
                hold = 1'b0;
                t.who  = who;
                t.addr = (who == 1) ? r1_addr_in : r0_addr_in;
                t.we   = (who == 1) ? r1_we_in   : r0_we_in;
                t.data = (who == 1) ? r1_data_in : r0_data_in;
                t.g    = edge_n;
                sb.push_back(t);
                last_owner = who;
                cur_g = edge_n;
                cur_who = who;
                next_free = edge_n + W + 3;
            end
        end
    end

    // Monitor: cycle offset from grant decides the expected bus phase.
    always @(negedge clk_in) begin
        txn_t        t;
        int          off;
        logic [31:0] exp;
        bit          ack_now;
        if (rst_in) begin
            ack_now = 1'b0;
            if (sb.size() > 0) begin
                t = sb[0];
                off = edge_n - t.g;
                ack_now = (off >= W + 1);
                exp = {11'b0, 1'b1, 1'(t.who), t.addr, (off >= 1 && off <= W) && t.we, t.we,
                       t.we ? t.data : 8'h00, ack_now && t.who == 0, ack_now && t.who == 1};
            end else begin
                exp = {11'b0, 1'b0, 1'(last_owner), 7'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0};
            end
            chk("bus", pack_outs(), exp);
            if (ack_now) begin
                if (!t.we) exp_rd[t.who] = mem[t.addr];
                void'(sb.pop_front());
            end
            chk("rdata", {16'b0, r1_data_out, r0_data_out}, {16'b0, exp_rd[1], exp_rd[0]});
        end
    end

    task automatic drive_random(input int req_pct, input int halt_pct, input int we_pct);
        r0_req_in  = ($urandom_range(99) < req_pct);
        r1_req_in  = ($urandom_range(99) < req_pct);
        halt_in    = ($urandom_range(99) < halt_pct);
        r0_addr_in = 7'($urandom);
        r1_addr_in = 7'($urandom);
        r0_we_in   = ($urandom_range(99) < we_pct);
        r1_we_in   = ($urandom_range(99) < we_pct);
        r0_data_in = 8'($urandom);
        r1_data_in = 8'($urandom);
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 128; i++) mem[i] = 8'($urandom);
        model_reset();
        #1 rst_in = 1'b0;
        #2;
        chk("reset_outs", pack_outs(),
            {11'b0, 1'b0, 1'b1, 7'd0, 1'b0, 1'b0, 8'd0, 1'b0, 1'b0});
        chk("reset_rdata", {16'b0, r1_data_out, r0_data_out}, 32'd0);
        repeat (2) @(negedge clk_in);
        #2 rst_in = 1'b1;

        for (int c = 0; c < 700; c++) begin
            @(negedge clk_in);
            if (c < 150)      drive_random(60, 8, 50);
            else if (c < 250) drive_random(100, 0, 50);
            else if (c < 300) drive_random(100, 100, 50);
            else if (c == 300) begin
                // Force a write and reset in the middle of its ACCESS phase.
                drive_random(0, 0, 0);
                r0_req_in = 1'b1;
                r0_we_in  = 1'b1;
                seen = 1'b0;
                for (int k = 0; k < 40 && !seen; k++) begin
                    @(negedge clk_in);
                    seen = bus_we_out;
                end
                chk("write_access_seen", {31'b0, seen}, 32'd1);
                @(posedge clk_in);
                #2 rst_in = 1'b0;
                model_reset();
                #1;
                chk("rst_mid", {28'b0, busy_out, bus_we_out, bus_drive_out, r0_ack_out | r1_ack_out},
                    32'd0);
                r1_req_in = 1'b1;
                repeat (2) @(negedge clk_in);
                #2 rst_in = 1'b1;
            end
            else if (c < 500) drive_random(70, 5, 40);
            else              drive_random(95, 3, 50);
`ifdef MINIBYTE_ARB_LOCK_EN
            r0_lock_in = (c >= 500) ? 1'b0 : ($urandom_range(3) == 0);
            r1_lock_in = (c >= 500) ? 1'b1 : ($urandom_range(3) == 0);
`endif
        end
        repeat (W + 4) @(negedge clk_in);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
